// File: rtl/fft_capture_pkg.sv
// Shared types and width helpers for the double-buffered FFT frame capture block.
package fft_capture_pkg;

  localparam int NFFT_DEFAULT = 8;
  localparam int DW_DEFAULT   = 32;

  // $clog2 returns 0 for n <= 1; a zero-width vector is never legal here.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_w(input int nfft);
    return clog2_safe(nfft);
  endfunction

  function automatic int addr_w(input int nfft);
    return clog2_safe(2 * nfft);
  endfunction

  localparam int IDX_W_DEFAULT  = idx_w(NFFT_DEFAULT);
  localparam int ADDR_W_DEFAULT = addr_w(NFFT_DEFAULT);

  typedef logic bank_t;

endpackage

// File: rtl/fft_frame_capture_if.sv
// AXI-Stream sample channel carrying one complex FFT bin per beat as {IM, RE}.
interface fft_frame_capture_if #(
  parameter int DW = 32
) ();
  // A beat transfers on a rising edge where tvalid and tready are both high.
  // The source holds tdata/tlast stable while tvalid is high and tready is low;
  // the sink may drop tready at any time without waiting for tvalid.
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [2*DW-1:0] tdata;

  modport master (output tvalid, tlast, tdata, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/fft_capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read cleared by reset.
module fft_capture_ram #(
  parameter int AW = 4,
  parameter int W  = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_frame_capture.sv
// Double-buffered AXI-Stream sink for FFT frames: one bank fills while the host
// reads the other, with tlast framing checks and an explicit release handshake.
module fft_frame_capture
  import fft_capture_pkg::*;
#(
  parameter  int NFFT   = NFFT_DEFAULT,
  parameter  int DW     = DW_DEFAULT,
  localparam int IDX_W  = idx_w(NFFT),
  localparam int ADDR_W = addr_w(NFFT)
) (
  input  logic                clk,
  input  logic                resetn,
  fft_frame_capture_if.slave  s_axis,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                frame_ready,
  input  logic                rd_release,
  output logic                receiving,
  output logic                frame_err,
  output logic [15:0]         frame_count
);

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  bank_t            wbank;
  bank_t            rbank;
  logic [IDX_W-1:0] idx;
  logic             sel_im;
  logic [2*DW-1:0]  ram_q;

  logic accept;
  logic last_slot;
  logic commit;
  logic early_last;
  logic release_ok;

  assign s_axis.tready = resetn & ~full[wbank];

  assign accept     = s_axis.tvalid & s_axis.tready;
  assign last_slot  = (idx == IDX_W'(NFFT - 1));
  assign commit     = accept & last_slot;
  assign early_last = accept & s_axis.tlast & ~last_slot;
  assign release_ok = rd_release & full[rbank];

  // Commit marks the write bank full; release frees the read bank. When both
  // fire together the write bank was empty, so they never target the same bit.
  always_comb begin
    full_nxt = full;
    if (commit) begin
      full_nxt[wbank] = 1'b1;
    end
    if (release_ok) begin
      full_nxt[rbank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      full        <= '0;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      idx         <= '0;
      frame_count <= '0;
      frame_err   <= 1'b0;
      sel_im      <= 1'b0;
    end else begin
      full      <= full_nxt;
      frame_err <= (commit & ~s_axis.tlast) | early_last;
      sel_im    <= rd_addr[0];
      if (commit) begin
        wbank       <= ~wbank;
        frame_count <= frame_count + 16'd1;
      end
      if (release_ok) begin
        rbank <= ~rbank;
      end
      // An early tlast drops the partial frame by rewinding the write index.
      if (commit || early_last) begin
        idx <= '0;
      end else if (accept) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  fft_capture_ram #(
    .AW (ADDR_W),
    .W  (2 * DW)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (accept),
    .waddr  ({wbank, idx}),
    .wdata  (s_axis.tdata),
    .raddr  ({rbank, rd_addr[ADDR_W-1:1]}),
    .rdata  (ram_q)
  );

  assign rd_data     = sel_im ? ram_q[2*DW-1:DW] : ram_q[DW-1:0];
  assign frame_ready = full[rbank];
  assign receiving   = (idx != '0);

endmodule

// File: doc/fft_frame_capture.md
# fft_frame_capture

Parametrised, double-buffered AXI-Stream sink for FFT result frames. Accepts NFFT complex samples per frame into one of two RAM banks while the host reads the previously completed frame from the other bank. Adds true tvalid/tready backpressure, tlast framing checks and an explicit host release handshake. Sits between the FFT core output and the AXI-Lite register/readback logic.

## Interface
- NFFT, 8, samples per frame; power of two, >= 4
- DW, 32, width of one real or imaginary component
- clk  in  1  clock, all logic rising-edge
- resetn  in  1  reset resetn, synchronous, active-low; clock clk
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  sink ready
- s_axis_tlast  in  1  last sample of frame
- s_axis_tdata  in  2*DW  {IM, RE}
- rd_addr  in  $clog2(2*NFFT)  word address; even = RE[k], odd = IM[k], k = rd_addr>>1
- rd_data  out  DW  word from read bank, 1-cycle latency
- frame_ready  out  1  read bank holds a complete frame
- rd_release  in  1  single-cycle pulse; host done with read bank
- receiving  out  1  partial frame in progress
- frame_err  out  1  one-cycle pulse on framing error
- frame_count  out  16  committed frames, wraps at 2^16

## Operation
- Two banks, each NFFT x 2*DW. Registers: full[1:0], wbank, rbank, idx ($clog2(NFFT) bits).
- s_axis_tready = resetn & ~full[wbank]. This is the only combinational output.
- Beat accepted when tvalid & tready. Sample stored at {wbank, idx}. idx increments.
- Accepted beat with idx == NFFT-1 commits the frame: full[wbank] <= 1, wbank toggles, idx <= 0, frame_count increments.
  - If tlast is low on this beat, frame_err pulses. The frame is still committed.
- Accepted beat with tlast high and idx < NFFT-1 is an early tlast: frame_err pulses, idx <= 0, and the bank is not marked full. The partial frame is discarded and the next beat starts a new frame.
- frame_ready = full[rbank].
- rd_release while frame_ready: full[rbank] <= 0, rbank toggles. rd_release while frame_ready is low is ignored.
- Commit and release in the same cycle both take effect; they always target different banks.
- receiving = (idx != 0).
- Synchronous reset clears full, wbank, rbank, idx and frame_count. Reset mid-frame discards the partial frame. Reset values: tready 0 during reset and 1 on the first cycle after; frame_ready 0; receiving 0; frame_err 0; frame_count 0; rd_data 0.
- Write and read banks are always distinct whenever frame_ready is high, so no read/write collision exists.

## Timing
- Write: one sample per cycle sustained while a bank is free; no bubbles between frames.
- frame_ready rises on the cycle after the final beat of a frame is accepted.
- rd_data is registered: it reflects rd_addr and rbank sampled on the previous edge. Reads are valid from the first cycle frame_ready is high.
- After rd_release at edge t, rbank switches at t. rd_data reflects the new bank from edge t+1.
- With both banks full, tready is low from the cycle after the second commit until the cycle after rd_release.
- frame_err is asserted on the cycle after the offending beat, for exactly one cycle.

## Structure
- Package fft_capture_pkg holds:
  - function clog2_safe
  - localparam index/address width helpers
  - a bank-select type (1 bit)
- Sub-module fft_capture_ram: simple dual-port RAM, 2*NFFT entries x 2*DW bits, synchronous write and registered read.
  - Write address {wbank, idx}.
  - Read address {rbank, rd_addr>>1}.
  - Top level selects RE or IM using registered rd_addr[0].
- Top level holds bank/handshake control and framing checks.

## Test plan
- NFFT=8, DW=32. Send samples k=0..7 with RE=k, IM=0x100+k, tlast on k=7. Expect frame_ready=1 the next cycle, frame_count=1, no frame_err. Reading addr 0..15 returns 0,0x100,1,0x101,…,7,0x107.
- Send two back-to-back frames without release, then attempt a third. Expect tready=0 after the second commit and no third-frame data written. Pulse rd_release. Expect tready=1 the next cycle, and frame 2 readable.
- Assert tlast on k=4. Expect a frame_err pulse, no commit, frame_count unchanged. The following 8-beat frame commits cleanly.
- Send 8 beats with tlast low. Expect frame committed, frame_err pulse, frame_count incremented.
- Random tvalid gaps and rd_release landing on the same cycle as a commit. Expect both to take effect, with data matching a scoreboard over 1000 frames.
- Assert resetn low after 3 beats. Expect receiving=0, frame_ready=0 and tready=1 on the first cycle after reset. The next frame begins at sample index 0.
